dma_channel_arbiter: RTL and testbench
======================================

Name: dma_channel_arbiter

Overview:
- Producer side of the DMA control-unit handshake.
- Picks one of two requesting DMA channels using priority, with round-robin on ties, then pulses `arbitrate`.
- While the channel owns the engines, counts burst completions on the read and write engines and raises the `give1`/`give2` release flags back to the control unit.
- Holds the current grant across a CPU configuration interrupt and drives `validChannels` so the channel path can resume afterwards.

Parameters:
- QUANTUM, 4: max bursts per engine per grant before forced release (≥1).
- CNT_W, 8: width of the burst counters; QUANTUM ≤ 2^CNT_W − 1.
- AGE_LIMIT, 3: consecutive losses that force a win (used only with the optional feature).

Ports:
- AXI_aclk  in  1  clock
- AXI_aresetn  in  1  asynchronous active-low reset
- muxSel1  in  1  control-unit select; 0 = arbitration path, 1 = channel path
- CPU_interrupt_CFG  in  1  CPU config interrupt start (level)
- CPU_interrupt_end  in  1  CPU config interrupt finished (pulse)
- ch_req  in  2  per-channel transfer request, level
- ch_prio  in  2  per-channel priority bit; 1 = high
- rd_burst_done  in  1  read engine completed one burst (pulse)
- rd_last  in  1  read engine finished whole transfer (pulse)
- wr_burst_done  in  1  write engine completed one burst (pulse)
- wr_last  in  1  write engine finished whole transfer (pulse)
- arbitrate  out  1  one-cycle pulse: grant issued
- winner  out  1  index of the granted channel
- validChannels  out  1  a held grant is still requested
- give1  out  1  read engine released (sticky)
- give2  out  1  write engine released (sticky)

Behaviour:
- Reset (asynchronous, active-low, applied on `AXI_aresetn`): state = IDLE; all outputs 0; both counters 0; `last_winner` = 1, so channel 0 wins the first tie.

State IDLE:
- If muxSel1 = 0 and ch_req ≠ 0 → ARB. The winner is computed combinationally and registered on this edge.

Winner rule (evaluated in IDLE):
- Only one request: that channel wins.
- Both requesting, priorities differ: the high-priority channel wins.
- Both requesting, priorities equal: the channel ≠ `last_winner` wins.

State ARB (exactly 1 cycle):
- `arbitrate` = 1.
- `winner` is valid and held stable until the next ARB.
- `last_winner` is updated to `winner`.
- Both burst counters and both give flags are cleared.
- Next state is ACTIVE.

State ACTIVE, read engine:
- On `rd_burst_done`, the read counter increments.
- `give1` is set when (rd_burst_done and counter = QUANTUM−1) or rd_last.
- Once set, `give1` stays high and further read pulses are ignored.
- `rd_last` and the quantum hit on the same cycle set `give1` once.

State ACTIVE, write engine:
- Same rules as the read engine, driving `give2` from `wr_burst_done`/`wr_last`.

State ACTIVE, exits:
- give1 and give2 both 1 → RELEASE.
- CPU_interrupt_CFG = 1 → SUSPEND (CFG has priority over the release check on the same cycle).
- A drop in the winner's request is ignored; release happens only through the give flags.

State RELEASE:
- Both give flags are held.
- When muxSel1 = 0 is observed: clear the give flags and go to IDLE.
- The earliest re-arbitration is one cycle after that.

State SUSPEND:
- Counters, give flags and `winner` are frozen.
- Engine pulses are ignored.
- On CPU_interrupt_end → ACTIVE.

validChannels:
- Equals 1 when state ∈ {ACTIVE, SUSPEND} and ch_req[winner] = 1.
- Registered: it reflects the previous cycle's state.

Other rules:
- The counters saturate at QUANTUM−1 and never wrap.
- Reset asserted mid-transfer returns the block to IDLE immediately; no pulse is emitted.
- `arbitrate` never rises in two consecutive cycles.

Optional Feature:
- Macro: DMA_ARB_AGING_EN.
- Defined:
  - A 2-bit-plus loss counter per channel counts ARB cycles where that channel was requesting but lost.
  - When a counter reaches AGE_LIMIT, that channel wins the next arbitration regardless of priority.
  - A channel's counter clears when it wins.
- Not defined: pure priority plus round-robin as above, and the AGE_LIMIT parameter is unused.

Test Plan:
1. ch_req=01 from reset, muxSel1=0 → arbitrate pulses in the 2nd cycle after the request; winner=0. Drive 4 rd_burst_done → give1 rises on the 4th. Drive 4 wr_burst_done → give2 rises; state goes to RELEASE. muxSel1=0 → gives clear next cycle.
2. ch_req=11, ch_prio=00, three back-to-back grants each closed by rd_last+wr_last → winner sequence 0,1,0.
3. ch_req=11, ch_prio=10 → winner=1 on every grant. Additionally, with DMA_ARB_AGING_EN and AGE_LIMIT=3, the 4th grant goes to channel 0.
4. In ACTIVE after 2 read bursts, CPU_interrupt_CFG=1 → SUSPEND; validChannels=1; 3 rd_burst_done pulses are ignored. CPU_interrupt_end → ACTIVE; 2 more bursts → give1 rises, confirming the count resumed from 2.
5. rd_last and rd_burst_done both asserted with counter=QUANTUM−1 → give1 set once; the counter stays at QUANTUM−1.
6. AXI_aresetn deasserted (reset applied) during ACTIVE with give1=1 → all outputs 0 asynchronously. After release with ch_req=11, prio equal → winner=0.

Source files
------------

// File: rtl/dma_channel_arbiter.sv
// Two-channel DMA arbiter: priority/round-robin grant, per-engine burst quanta, CPU-config suspend.
// Optional loss-aging override is compiled in with `define DMA_ARB_AGING_EN.
module dma_channel_arbiter #(
  parameter int unsigned QUANTUM   = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned AGE_LIMIT = 3
) (
  input  logic       AXI_aclk,
  input  logic       AXI_aresetn,
  input  logic       muxSel1,
  input  logic       CPU_interrupt_CFG,
  input  logic       CPU_interrupt_end,
  input  logic [1:0] ch_req,
  input  logic [1:0] ch_prio,
  input  logic       rd_burst_done,
  input  logic       rd_last,
  input  logic       wr_burst_done,
  input  logic       wr_last,
  output logic       arbitrate,
  output logic       winner,
  output logic       validChannels,
  output logic       give1,
  output logic       give2
);

  if (QUANTUM < 1 || AGE_LIMIT < 1 ||
      longint'(QUANTUM) > (longint'(1) << CNT_W) - longint'(1)) begin : g_bad_cfg
    $error("dma_channel_arbiter: illegal QUANTUM/CNT_W/AGE_LIMIT combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ACTIVE,
    ST_RELEASE,
    ST_SUSPEND
  } state_t;

  localparam logic [CNT_W-1:0] QMAX = CNT_W'(QUANTUM - 1);

  state_t           state_q, state_d;
  logic             winner_q, winner_d;
  logic             last_winner_q, last_winner_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             give1_q, give1_d;
  logic             give2_q, give2_d;
  logic             valid_q, valid_d;
  logic             pick;

`ifdef DMA_ARB_AGING_EN
  localparam int unsigned AGE_W = (AGE_LIMIT < 4) ? 2 : $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic [1:0][AGE_W-1:0] age_q, age_d;
  logic [1:0]            aged;

  assign aged = {age_q[1] >= AGE_MAX, age_q[0] >= AGE_MAX};
`endif

  // Grant candidate, only consumed on the IDLE -> ARB edge
  always_comb begin
    pick = 1'b0;
    if (ch_req != 2'b11) begin
      pick = ch_req[1];
    end else if (ch_prio[0] != ch_prio[1]) begin
      pick = ch_prio[1];
    end else begin
      pick = ~last_winner_q;
    end
`ifdef DMA_ARB_AGING_EN
    // A starved channel overrides priority only when both are contending
    if (ch_req == 2'b11) begin
      if (aged == 2'b01) begin
        pick = 1'b0;
      end else if (aged == 2'b10) begin
        pick = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    give1_d       = give1_q;
    give2_d       = give2_q;
`ifdef DMA_ARB_AGING_EN
    age_d         = age_q;
`endif
    valid_d = ((state_q == ST_ACTIVE) || (state_q == ST_SUSPEND)) && ch_req[winner_q];

    unique case (state_q)
      ST_IDLE: begin
        if (!muxSel1 && (ch_req != 2'b00)) begin
          state_d  = ST_ARB;
          winner_d = pick;
        end
      end

      ST_ARB: begin
        last_winner_d = winner_q;
        rd_cnt_d      = '0;
        wr_cnt_d      = '0;
        give1_d       = 1'b0;
        give2_d       = 1'b0;
        state_d       = ST_ACTIVE;
`ifdef DMA_ARB_AGING_EN
        for (int unsigned i = 0; i < 2; i++) begin
          if (winner_q == 1'(i)) begin
            age_d[i] = '0;
          end else if (ch_req[i] && (age_q[i] != AGE_MAX)) begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end
        end
`endif
      end

      ST_ACTIVE: begin
        // Config interrupt wins over a same-cycle release; engine pulses that cycle are dropped
        if (CPU_interrupt_CFG) begin
          state_d = ST_SUSPEND;
        end else begin
          if (give1_q && give2_q) begin
            state_d = ST_RELEASE;
          end
          if (!give1_q) begin
            if (rd_burst_done && (rd_cnt_q != QMAX)) begin
              rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
            if ((rd_burst_done && (rd_cnt_q == QMAX)) || rd_last) begin
              give1_d = 1'b1;
            end
          end
          if (!give2_q) begin
            if (wr_burst_done && (wr_cnt_q != QMAX)) begin
              wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
            if ((wr_burst_done && (wr_cnt_q == QMAX)) || wr_last) begin
              give2_d = 1'b1;
            end
          end
        end
      end

      ST_RELEASE: begin
        if (!muxSel1) begin
          give1_d = 1'b0;
          give2_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      ST_SUSPEND: begin
        if (CPU_interrupt_end) begin
          state_d = ST_ACTIVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state_q       <= ST_IDLE;
      winner_q      <= 1'b0;
      last_winner_q <= 1'b1;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      give1_q       <= 1'b0;
      give2_q       <= 1'b0;
      valid_q       <= 1'b0;
`ifdef DMA_ARB_AGING_EN
      age_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      give1_q       <= give1_d;
      give2_q       <= give2_d;
      valid_q       <= valid_d;
`ifdef DMA_ARB_AGING_EN
      age_q         <= age_d;
`endif
    end
  end

  assign arbitrate     = (state_q == ST_ARB);
  assign winner        = winner_q;
  assign validChannels = valid_q;
  assign give1         = give1_q;
  assign give2         = give2_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed plus randomized bench for dma_channel_arbiter against a rule-level grant/quantum model.
module tb_dma_channel_arbiter;

  localparam int unsigned QUANTUM   = 4;
  localparam int unsigned AGE_LIMIT = 3;

  logic       AXI_aclk;
  logic       AXI_aresetn;
  logic       muxSel1;
  logic       CPU_interrupt_CFG;
  logic       CPU_interrupt_end;
  logic [1:0] ch_req;
  logic [1:0] ch_prio;
  logic       rd_burst_done;
  logic       rd_last;
  logic       wr_burst_done;
  logic       wr_last;
  logic       arbitrate;
  logic       winner;
  logic       validChannels;
  logic       give1;
  logic       give2;

  int checks = 0;
  int errors = 0;

  // Reference model: who won last, and how many arbitrations each channel has lost in a row
  logic m_last;
  int   m_age [2];

  dma_channel_arbiter #(
    .QUANTUM  (QUANTUM),
    .CNT_W    (8),
    .AGE_LIMIT(AGE_LIMIT)
  ) dut (
    .AXI_aclk         (AXI_aclk),
    .AXI_aresetn      (AXI_aresetn),
    .muxSel1          (muxSel1),
    .CPU_interrupt_CFG(CPU_interrupt_CFG),
    .CPU_interrupt_end(CPU_interrupt_end),
    .ch_req           (ch_req),
    .ch_prio          (ch_prio),
    .rd_burst_done    (rd_burst_done),
    .rd_last          (rd_last),
    .wr_burst_done    (wr_burst_done),
    .wr_last          (wr_last),
    .arbitrate        (arbitrate),
    .winner           (winner),
    .validChannels    (validChannels),
    .give1            (give1),
    .give2            (give2)
  );

  initial AXI_aclk = 1'b0;
  always #5 AXI_aclk = ~AXI_aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge AXI_aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last   = 1'b1;
    m_age[0] = 0;
    m_age[1] = 0;
  endtask

  function automatic logic model_pick(input logic [1:0] req, input logic [1:0] prio);
    if (req == 2'b01) return 1'b0;
    if (req == 2'b10) return 1'b1;
`ifdef DMA_ARB_AGING_EN
    if (m_age[0] >= int'(AGE_LIMIT) && m_age[1] < int'(AGE_LIMIT)) return 1'b0;
    if (m_age[1] >= int'(AGE_LIMIT) && m_age[0] < int'(AGE_LIMIT)) return 1'b1;
`endif
    if (prio[0] != prio[1]) return prio[1];
    return ~m_last;
  endfunction

  task automatic model_grant(input logic [1:0] req, input logic w);
    m_last = w;
    m_age[w] = 0;
    if (req[~w] && m_age[~w] < int'(AGE_LIMIT)) m_age[~w]++;
  endtask

  task automatic do_reset();
    AXI_aresetn       = 1'b0;
    muxSel1           = 1'b0;
    CPU_interrupt_CFG = 1'b0;
    CPU_interrupt_end = 1'b0;
    ch_req            = 2'b00;
    ch_prio           = 2'b00;
    rd_burst_done     = 1'b0;
    rd_last           = 1'b0;
    wr_burst_done     = 1'b0;
    wr_last           = 1'b0;
    model_reset();
    repeat (2) @(posedge AXI_aclk);
    @(negedge AXI_aclk);
    AXI_aresetn = 1'b1;
    tick();
  endtask

  // Expects the DUT idle; returns one cycle after the grant pulse with muxSel1 held high
  task automatic grant(input logic [1:0] req, input logic [1:0] prio, input logic exp_w,
                       input string tag);
    ch_req  = req;
    ch_prio = prio;
    muxSel1 = 1'b0;
    tick();
    chk($sformatf("%s_arb", tag), 32'(arbitrate), 32'd1);
    chk($sformatf("%s_win", tag), 32'(winner), 32'(exp_w));
    model_grant(req, exp_w);
    muxSel1 = 1'b1;
    tick();
    chk($sformatf("%s_arb_end", tag), 32'(arbitrate), 32'd0);
    chk($sformatf("%s_win_hold", tag), 32'(winner), 32'(exp_w));
  endtask

  task automatic rd_pulse();
    rd_burst_done = 1'b1;
    tick();
    rd_burst_done = 1'b0;
  endtask

  task automatic wr_pulse();
    wr_burst_done = 1'b1;
    tick();
    wr_burst_done = 1'b0;
  endtask

  // Forces both releases, holds RELEASE, then drops muxSel1; leaves the DUT idle
  task automatic close_grant(input string tag);
    rd_last = 1'b1;
    wr_last = 1'b1;
    tick();
    rd_last = 1'b0;
    wr_last = 1'b0;
    chk($sformatf("%s_g1", tag), 32'(give1), 32'd1);
    chk($sformatf("%s_g2", tag), 32'(give2), 32'd1);
    tick();
    tick();
    chk($sformatf("%s_g1_hold", tag), 32'(give1), 32'd1);
    chk($sformatf("%s_g2_hold", tag), 32'(give2), 32'd1);
    muxSel1 = 1'b0;
    tick();
    chk($sformatf("%s_g1_clr", tag), 32'(give1), 32'd0);
    chk($sformatf("%s_g2_clr", tag), 32'(give2), 32'd0);
    chk($sformatf("%s_no_arb", tag), 32'(arbitrate), 32'd0);
  endtask

  initial begin
    logic [1:0] rreq;
    logic [1:0] rprio;
    logic       rw;
    int unsigned nr;
    int unsigned nw;

    // 1: single request, quantum release on both engines
    do_reset();
    chk("rst_arb", 32'(arbitrate), 32'd0);
    chk("rst_win", 32'(winner), 32'd0);
    chk("rst_valid", 32'(validChannels), 32'd0);
    chk("rst_g1", 32'(give1), 32'd0);
    chk("rst_g2", 32'(give2), 32'd0);
    ch_req = 2'b01;
    #1;
    chk("t1_pre_arb", 32'(arbitrate), 32'd0);
    grant(2'b01, 2'b00, 1'b0, "t1");
    for (int i = 0; i < 4; i++) begin
      rd_pulse();
      chk($sformatf("t1_rd%0d", i), 32'(give1), 32'(i == 3));
    end
    for (int i = 0; i < 4; i++) begin
      wr_pulse();
      chk($sformatf("t1_wr%0d", i), 32'(give2), 32'(i == 3));
    end
    tick();
    tick();
    chk("t1_rel_g1", 32'(give1), 32'd1);
    chk("t1_rel_g2", 32'(give2), 32'd1);
    chk("t1_rel_valid", 32'(validChannels), 32'd0);
    muxSel1 = 1'b0;
    ch_req  = 2'b00;
    tick();
    chk("t1_clr_g1", 32'(give1), 32'd0);
    chk("t1_clr_g2", 32'(give2), 32'd0);

    // 2: equal priority round-robin from reset
    do_reset();
    grant(2'b11, 2'b00, 1'b0, "t2a");
    close_grant("t2a");
    grant(2'b11, 2'b00, 1'b1, "t2b");
    close_grant("t2b");
    grant(2'b11, 2'b00, 1'b0, "t2c");
    close_grant("t2c");

    // 3: channel 1 high priority; aging hands the 4th grant to channel 0
    for (int i = 0; i < 3; i++) begin
      grant(2'b11, 2'b10, 1'b1, $sformatf("t3_%0d", i));
      close_grant($sformatf("t3_%0d", i));
    end
`ifdef DMA_ARB_AGING_EN
    grant(2'b11, 2'b10, 1'b0, "t3_3");
`else
    grant(2'b11, 2'b10, 1'b1, "t3_3");
`endif
    close_grant("t3_3");

    // 4: suspend freezes the read count
    grant(2'b01, 2'b00, 1'b0, "t4");
    rd_pulse();
    rd_pulse();
    CPU_interrupt_CFG = 1'b1;
    tick();
    chk("t4_valid_susp", 32'(validChannels), 32'd1);
    for (int i = 0; i < 3; i++) begin
      rd_pulse();
      chk($sformatf("t4_susp_rd%0d", i), 32'(give1), 32'd0);
    end
    CPU_interrupt_CFG = 1'b0;
    CPU_interrupt_end = 1'b1;
    tick();
    CPU_interrupt_end = 1'b0;
    chk("t4_valid_resume", 32'(validChannels), 32'd1);
    rd_pulse();
    chk("t4_rd3", 32'(give1), 32'd0);
    rd_pulse();
    chk("t4_rd4", 32'(give1), 32'd1);
    close_grant("t4");

    // 5: last and quantum-hit on the same cycle
    grant(2'b01, 2'b00, 1'b0, "t5");
    for (int i = 0; i < 3; i++) rd_pulse();
    chk("t5_pre", 32'(give1), 32'd0);
    rd_burst_done = 1'b1;
    rd_last       = 1'b1;
    tick();
    rd_burst_done = 1'b0;
    rd_last       = 1'b0;
    chk("t5_both", 32'(give1), 32'd1);
    rd_pulse();
    chk("t5_sticky", 32'(give1), 32'd1);
    chk("t5_g2", 32'(give2), 32'd0);
    close_grant("t5");

    // Randomized grants and burst counts against the model
    for (int it = 0; it < 24; it++) begin
      rreq  = 2'($urandom_range(1, 3));
      rprio = 2'($urandom_range(0, 3));
      rw    = model_pick(rreq, rprio);
      grant(rreq, rprio, rw, $sformatf("rnd%0d", it));
      nr = $urandom_range(0, QUANTUM + 1);
      nw = $urandom_range(0, QUANTUM + 1);
      for (int unsigned k = 0; k < nr; k++) begin
        rd_pulse();
        chk($sformatf("rnd%0d_rd%0d", it, k), 32'(give1), 32'((k + 1) >= QUANTUM));
      end
      for (int unsigned k = 0; k < nw; k++) begin
        wr_pulse();
        chk($sformatf("rnd%0d_wr%0d", it, k), 32'(give2), 32'((k + 1) >= QUANTUM));
      end
      close_grant($sformatf("rnd%0d", it));
    end

    // 6: asynchronous reset mid-transfer
    grant(2'b01, 2'b00, 1'b0, "t6");
    rd_last = 1'b1;
    tick();
    rd_last = 1'b0;
    chk("t6_g1", 32'(give1), 32'd1);
    #2;
    AXI_aresetn = 1'b0;
    #1;
    chk("t6_async_arb", 32'(arbitrate), 32'd0);
    chk("t6_async_valid", 32'(validChannels), 32'd0);
    chk("t6_async_g1", 32'(give1), 32'd0);
    chk("t6_async_g2", 32'(give2), 32'd0);
    chk("t6_async_win", 32'(winner), 32'd0);
    do_reset();
    grant(2'b11, 2'b00, 1'b0, "t6_post");
    close_grant("t6_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
